// File: rtl/sdp_ram_pkg.sv
// Shared types and helpers for the byte-enable simple dual-port RAM.
// Holds the FSM and collision-mode enums plus the lane parity function.
package sdp_ram_pkg;

   localparam int MAX_RD_LAT = 2;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } sdp_ram_state_e;

   typedef enum logic [0:0] {
      COLL_WRITE_FIRST = 1'b0,
      COLL_READ_FIRST  = 1'b1
   } sdp_ram_coll_e;

   function automatic sdp_ram_coll_e coll_from_str(input string s);
      return (s == "read_first") ? COLL_READ_FIRST : COLL_WRITE_FIRST;
   endfunction

   function automatic bit coll_str_ok(input string s);
      return (s == "write_first") || (s == "read_first");
   endfunction

   // Even parity: the stored bit makes the lane plus parity have an even count of ones.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sdp_ram_clr_fsm.sv
// Post-reset clear sweep: walks every address once, then holds READY until reset.
// Latency: 2**AW clocks after reset release; no backpressure, runs unconditionally.
module sdp_ram_clr_fsm
   import sdp_ram_pkg::*;
#(
   parameter int AW         = 4,
   parameter bit CLR_ON_RST = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          init_done
);

   sdp_ram_state_e state;
   logic [AW-1:0]  cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLR_ON_RST ? CLEAR : READY;
         cnt   <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + AW'(1);
         // The edge that clears the last word also opens the RAM to traffic.
         if (cnt == '1) state <= READY;
      end
   end

   assign clr_we    = (state == CLEAR);
   assign clr_addr  = cnt;
   assign init_done = (state == READY);

endmodule

// File: rtl/sdp_ram_be_pipe.sv
// Simple dual-port RAM with byte-enable writes, 1/2-cycle read pipe and post-reset clear.
// No backpressure; per-lane parity and par_err exist only with SDP_RAM_PARITY_EN.
module sdp_ram_be_pipe
   import sdp_ram_pkg::*;
#(
   parameter int    AW         = 4,
   parameter int    DW         = 16,
   parameter int    RD_LAT     = 1,
   parameter string COLLISION  = "write_first",
   parameter bit    CLR_ON_RST = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wen,
   input  logic [DW/8-1:0] wbe,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   din,
   input  logic            ren,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   dout,
   output logic            dout_vld,
   output logic            init_done
`ifdef SDP_RAM_PARITY_EN
   ,
   output logic            par_err
`endif
);

   localparam int            NB    = DW / 8;
   localparam int            DEPTH = 1 << AW;
   localparam sdp_ram_coll_e COLL  = coll_from_str(COLLISION);

   if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_rd_lat
      $error("sdp_ram_be_pipe: RD_LAT must be 1 or 2");
   end
   if (DW % 8 != 0) begin : g_bad_dw
      $error("sdp_ram_be_pipe: DW must be a multiple of 8");
   end
   if (!coll_str_ok(COLLISION)) begin : g_bad_coll
      $error("sdp_ram_be_pipe: COLLISION must be write_first or read_first");
   end

   logic          clr_we;
   logic [AW-1:0] clr_addr;

   sdp_ram_clr_fsm #(
      .AW        (AW),
      .CLR_ON_RST(CLR_ON_RST)
   ) u_clr_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .init_done(init_done)
   );

   logic [DW-1:0] mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_dat;
   logic [NB-1:0] mem_be;

   // The sweep owns the write port until init_done; user writes are dropped meanwhile.
   always_comb begin
      mem_we   = clr_we | (init_done & wen);
      mem_addr = clr_we ? clr_addr : waddr;
      mem_dat  = clr_we ? '0 : din;
      mem_be   = clr_we ? '1 : wbe;
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < NB; k++) begin
            if (mem_be[k]) mem[mem_addr][8*k +: 8] <= mem_dat[8*k +: 8];
         end
      end
   end

   logic          rd_acc;
   logic          coll_hit;
   logic [DW-1:0] old_word;
   logic [DW-1:0] merged;
   logic [DW-1:0] rd_word;

   always_comb begin
      rd_acc   = init_done & ren;
      old_word = mem[raddr];
      merged   = old_word;
      for (int k = 0; k < NB; k++) begin
         if (wbe[k]) merged[8*k +: 8] = din[8*k +: 8];
      end
      coll_hit = (COLL == COLL_WRITE_FIRST) && init_done && wen && (waddr == raddr);
      rd_word  = coll_hit ? merged : old_word;
   end

   logic [RD_LAT-1:0] pipe_vld;
   logic [DW-1:0]     pipe_dat [RD_LAT];

   // Each stage only reloads when a read moves into it, so dout holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_dat[i] <= '0;
      end else begin
         pipe_vld[0] <= rd_acc;
         if (rd_acc) pipe_dat[0] <= rd_word;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            if (pipe_vld[i-1]) pipe_dat[i] <= pipe_dat[i-1];
         end
      end
   end

   assign dout     = pipe_dat[RD_LAT-1];
   assign dout_vld = pipe_vld[RD_LAT-1];

`ifdef SDP_RAM_PARITY_EN
   logic [NB-1:0]     par_mem [DEPTH];
   logic [NB-1:0]     wr_par;
   logic [NB-1:0]     rd_par;
   logic              rd_perr;
   logic [RD_LAT-1:0] pipe_err;

   // The bypass path takes fresh parity for written lanes so merged data checks clean.
   always_comb begin
      wr_par  = '0;
      rd_par  = par_mem[raddr];
      rd_perr = 1'b0;
      for (int k = 0; k < NB; k++) begin
         wr_par[k] = byte_parity(mem_dat[8*k +: 8]);
         if (coll_hit && wbe[k]) rd_par[k] = byte_parity(din[8*k +: 8]);
         if (byte_parity(rd_word[8*k +: 8]) != rd_par[k]) rd_perr = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int k = 0; k < NB; k++) begin
            if (mem_be[k]) par_mem[mem_addr][k] <= wr_par[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_err <= '0;
      end else begin
         if (rd_acc) pipe_err[0] <= rd_perr;
         for (int i = 1; i < RD_LAT; i++) begin
            if (pipe_vld[i-1]) pipe_err[i] <= pipe_err[i-1];
         end
      end
   end

   assign par_err = pipe_vld[RD_LAT-1] & pipe_err[RD_LAT-1];
`endif

endmodule
